// File: rtl/sdram_avs_frontend.sv
// Avalon-MM slave front end for the SDRAM access controller: buffers requests in a
// small first-word-fall-through FIFO, bounds outstanding reads and returns read data in order.
module sdram_avs_frontend #(
  parameter int AVS_AW    = 24,
  parameter int AVS_DW    = 16,
  parameter int AVS_BYTE  = 2,
  parameter int REQ_DEPTH = 4,
  parameter int MAX_RD    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_done,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [AVS_AW-1:0]   avs_address,
  input  logic [AVS_DW-1:0]   avs_writedata,
  input  logic [AVS_BYTE-1:0] avs_byteenable,
  output logic                avs_waitrequest,
  output logic [AVS_DW-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic                bus_req_valid,
  output logic                bus_req_write,
  output logic [AVS_AW-1:0]   bus_req_address,
  output logic [AVS_DW-1:0]   bus_req_writedata,
  output logic [AVS_BYTE-1:0] bus_req_byteenable,
  input  logic                bus_req_ready,
  input  logic                bus_resp_valid,
  input  logic [AVS_DW-1:0]   bus_resp_readdata,
  output logic                err_rw_conflict,
  output logic                err_resp_underflow
);

  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = $clog2(MAX_RD + 1);

  typedef struct packed {
    logic                write;
    logic [AVS_AW-1:0]   address;
    logic [AVS_DW-1:0]   writedata;
    logic [AVS_BYTE-1:0] byteenable;
  } req_t;

  req_t          mem [REQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] rd_cnt;

  logic full;
  logic empty;
  logic accept;
  logic pop;
  logic rd_accept;
  logic rd_dec;

  assign full  = (count == (PW+1)'(REQ_DEPTH));
  assign empty = (count == '0);

  // rd_cnt covers reads still queued as well as reads already issued downstream
  assign avs_waitrequest = !init_done | full | (avs_read & !avs_write & (rd_cnt == CW'(MAX_RD)));
  assign accept          = (avs_read | avs_write) & !avs_waitrequest;
  assign rd_accept       = accept & avs_read & !avs_write;
  assign pop             = !empty & bus_req_ready;
  assign rd_dec          = bus_resp_valid & (rd_cnt != '0);

  assign bus_req_valid = !empty;
  assign {bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {avs_write, avs_address, avs_writedata, avs_byteenable};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt <= '0;
    end else begin
      case ({rd_accept, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + CW'(1);
        2'b01:   rd_cnt <= rd_cnt - CW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  // Responses are forwarded even on underflow; the flag only records the anomaly
  always_ff @(posedge clk) begin
    if (!reset) begin
      avs_readdatavalid  <= 1'b0;
      avs_readdata       <= '0;
      err_rw_conflict    <= 1'b0;
      err_resp_underflow <= 1'b0;
    end else begin
      avs_readdatavalid <= bus_resp_valid;
      if (bus_resp_valid) begin
        avs_readdata <= bus_resp_readdata;
      end
      if (avs_read & avs_write) begin
        err_rw_conflict <= 1'b1;
      end
      if (bus_resp_valid & (rd_cnt == '0)) begin
        err_resp_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_avs_frontend.sv
// Testbench for sdram_avs_frontend: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the front end.
module tb_sdram_avs_frontend;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BE = 2;
  localparam int DEPTH = 4;
  localparam int MAXRD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          avs_read;
  logic          avs_write;
  logic [AW-1:0] avs_address;
  logic [DW-1:0] avs_writedata;
  logic [BE-1:0] avs_byteenable;
  logic          avs_waitrequest;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;
  logic          bus_req_valid;
  logic          bus_req_write;
  logic [AW-1:0] bus_req_address;
  logic [DW-1:0] bus_req_writedata;
  logic [BE-1:0] bus_req_byteenable;
  logic          bus_req_ready;
  logic          bus_resp_valid;
  logic [DW-1:0] bus_resp_readdata;
  logic          err_rw_conflict;
  logic          err_resp_underflow;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BE-1:0] be;
  } mreq_t;

  mreq_t         q[$];
  int            out_rd;
  logic          m_rdv;
  logic [DW-1:0] m_rdata;
  logic          m_conf;
  logic          m_under;

  sdram_avs_frontend #(
    .AVS_AW(AW), .AVS_DW(DW), .AVS_BYTE(BE), .REQ_DEPTH(DEPTH), .MAX_RD(MAXRD)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .bus_req_valid(bus_req_valid),
    .bus_req_write(bus_req_write), .bus_req_address(bus_req_address),
    .bus_req_writedata(bus_req_writedata), .bus_req_byteenable(bus_req_byteenable),
    .bus_req_ready(bus_req_ready), .bus_resp_valid(bus_resp_valid),
    .bus_resp_readdata(bus_resp_readdata), .err_rw_conflict(err_rw_conflict),
    .err_resp_underflow(err_resp_underflow)
  );

  always #5 clk = ~clk;

  // A request stalls when init is pending, the queue is full, or a pure read would exceed the read budget
  function automatic logic exp_wait();
    return !init_done || (q.size() == DEPTH) || (avs_read && !avs_write && out_rd == MAXRD);
  endfunction

  // Advance one clock and update the reference model from the inputs seen at that edge
  task automatic tick();
    logic acc;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      out_rd = 0; m_rdv = 1'b0; m_rdata = '0; m_conf = 1'b0; m_under = 1'b0;
    end else begin
      acc = (avs_read || avs_write) && !exp_wait();
      if (avs_read && avs_write) m_conf = 1'b1;
      if (q.size() > 0 && bus_req_ready) void'(q.pop_front());
      if (acc) q.push_back('{avs_write, avs_address, avs_writedata, avs_byteenable});
      if (bus_resp_valid) begin
        if (out_rd == 0) m_under = 1'b1;
        else out_rd--;
        m_rdata = bus_resp_readdata;
      end
      m_rdv = bus_resp_valid;
      if (acc && avs_read && !avs_write) out_rd++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    avs_byteenable = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_readdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; init_done = 1'b0; idle_inputs();
    tick(); tick();
    #1;
    n_checks++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus_req_valid); end
    n_checks++; if (avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv: got %b expected 0", avs_readdatavalid); end
    n_checks++; if (avs_readdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", avs_readdata); end
    n_checks++; if (err_rw_conflict !== 1'b0 || err_resp_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", err_rw_conflict, err_resp_underflow); end
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_wait: got %b expected 1", avs_waitrequest); end
    reset = 1'b1;
  endtask

  task automatic test_init_gate();
    avs_write = 1'b1; avs_address = 24'h00ABCD; avs_writedata = 16'h1234; avs_byteenable = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (avs_waitrequest !== 1'b1 || bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL init_stall cyc %0d: got wait=%b valid=%b expected wait=1 valid=0", i, avs_waitrequest, bus_req_valid); end
      tick();
    end
    init_done = 1'b1;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL init_release: got wait=%b expected 0", avs_waitrequest); end
    tick();
    avs_write = 1'b0;
    #1;
    n_checks++; if (bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL init_valid: got %b expected 1", bus_req_valid); end
    n_checks++; if ({bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable} !== {1'b1, 24'h00ABCD, 16'h1234, 2'b10})
      begin n_fail++; $display("FAIL init_payload: got w=%b a=%h d=%h be=%b expected w=1 a=00abcd d=1234 be=10", bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable); end
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    #1;
    n_checks++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL init_drain: got valid=%b expected 0", bus_req_valid); end
  endtask

  task automatic test_fifo_full();
    bus_req_ready = 1'b0; avs_write = 1'b1; avs_byteenable = 2'b11;
    for (int i = 0; i < 4; i++) begin
      avs_address = 24'h10 + 24'(i); avs_writedata = 16'($urandom);
      #1;
      n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL full_accept %0d: got wait=%b expected 0", i, avs_waitrequest); end
      tick();
    end
    avs_address = 24'h14;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_stall: got wait=%b expected 1", avs_waitrequest); end
    bus_req_ready = 1'b1;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_no_bypass: got wait=%b expected 1", avs_waitrequest); end
    n_checks++; if (bus_req_address !== 24'h10) begin n_fail++; $display("FAIL full_head0: got %h expected 000010", bus_req_address); end
    tick();
    #1;
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL full_fifth_accept: got wait=%b expected 0", avs_waitrequest); end
    n_checks++; if (bus_req_address !== 24'h11) begin n_fail++; $display("FAIL full_head1: got %h expected 000011", bus_req_address); end
    tick();
    avs_write = 1'b0;
    for (int j = 2; j < 5; j++) begin
      #1;
      n_checks++; if (bus_req_valid !== 1'b1 || bus_req_address !== 24'h10 + 24'(j)) begin n_fail++; $display("FAIL full_order %0d: got valid=%b a=%h expected valid=1 a=%h", j, bus_req_valid, bus_req_address, 24'h10 + 24'(j)); end
      tick();
    end
    #1;
    n_checks++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got valid=%b expected 0", bus_req_valid); end
  endtask

  task automatic test_read_limit();
    bus_req_ready = 1'b1; avs_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      avs_address = 24'h20 + 24'(i);
      #1;
      n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rdlim_accept %0d: got wait=%b expected 0", i, avs_waitrequest); end
      tick();
    end
    avs_address = 24'h22;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rdlim_stall: got wait=%b expected 1", avs_waitrequest); end
    tick();
    bus_resp_valid = 1'b1; bus_resp_readdata = 16'hBEEF;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rdlim_stall2: got wait=%b expected 1", avs_waitrequest); end
    tick();
    bus_resp_valid = 1'b0; bus_resp_readdata = 16'h0;
    #1;
    n_checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 16'hBEEF) begin n_fail++; $display("FAIL rdlim_resp: got rdv=%b data=%h expected rdv=1 data=beef", avs_readdatavalid, avs_readdata); end
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rdlim_third: got wait=%b expected 0", avs_waitrequest); end
    tick();
    avs_read = 1'b0;
    #1;
    n_checks++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 16'hBEEF) begin n_fail++; $display("FAIL rdlim_hold: got rdv=%b data=%h expected rdv=0 data=beef", avs_readdatavalid, avs_readdata); end
  endtask

  task automatic test_same_cycle();
    bus_resp_valid = 1'b1; bus_resp_readdata = 16'h1111;
    tick();
    bus_resp_valid = 1'b0;
    tick();
    avs_read = 1'b1; avs_address = 24'h40; bus_resp_valid = 1'b1; bus_resp_readdata = 16'h2222;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL same_accept: got wait=%b expected 0", avs_waitrequest); end
    tick();
    bus_resp_valid = 1'b0; avs_address = 24'h41;
    #1;
    n_checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 16'h2222) begin n_fail++; $display("FAIL same_rdv: got rdv=%b data=%h expected rdv=1 data=2222", avs_readdatavalid, avs_readdata); end
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL same_cnt_one: got wait=%b expected 0", avs_waitrequest); end
    tick();
    avs_address = 24'h42;
    #1;
    n_checks++; if (avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL same_pulse_once: got rdv=%b expected 0", avs_readdatavalid); end
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL same_cnt_two: got wait=%b expected 1", avs_waitrequest); end
    avs_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_resp_valid = 1'b1; bus_resp_readdata = 16'($urandom);
      tick();
    end
    bus_resp_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (err_resp_underflow !== 1'b0) begin n_fail++; $display("FAIL same_no_underflow: got %b expected 0", err_resp_underflow); end
  endtask

  task automatic test_conflict();
    logic [DW-1:0] d;
    bus_req_ready = 1'b0; avs_read = 1'b1; avs_write = 1'b1; avs_address = 24'h5;
    avs_writedata = 16'h5A5A; avs_byteenable = 2'b01;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL conf_accept: got wait=%b expected 0", avs_waitrequest); end
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    #1;
    n_checks++; if ({bus_req_valid, bus_req_write, bus_req_address} !== {1'b1, 1'b1, 24'h5}) begin n_fail++; $display("FAIL conf_req: got valid=%b w=%b a=%h expected valid=1 w=1 a=000005", bus_req_valid, bus_req_write, bus_req_address); end
    n_checks++; if (err_rw_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_flag: got %b expected 1", err_rw_conflict); end
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    #1;
    n_checks++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL conf_single: got valid=%b expected 0", bus_req_valid); end
    d = 16'($urandom);
    bus_resp_valid = 1'b1; bus_resp_readdata = d;
    tick();
    bus_resp_valid = 1'b0;
    #1;
    n_checks++; if (err_resp_underflow !== 1'b1 || avs_readdatavalid !== 1'b1 || avs_readdata !== d) begin n_fail++; $display("FAIL underflow: got err=%b rdv=%b data=%h expected err=1 rdv=1 data=%h", err_resp_underflow, avs_readdatavalid, avs_readdata, d); end
    tick(); tick();
    #1;
    n_checks++; if (err_rw_conflict !== 1'b1 || err_resp_underflow !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b%b expected 11", err_rw_conflict, err_resp_underflow); end
  endtask

  task automatic test_reset_mid();
    bus_req_ready = 1'b0; avs_read = 1'b1; avs_address = 24'h30;
    tick();
    avs_address = 24'h31;
    tick();
    avs_read = 1'b0; avs_write = 1'b1; avs_address = 24'h32;
    tick();
    avs_write = 1'b0;
    #1;
    n_checks++; if (bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got valid=%b expected 1", bus_req_valid); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if ({bus_req_valid, avs_readdatavalid, err_rw_conflict, err_resp_underflow} !== 4'b0000 || avs_readdata !== 16'h0)
      begin n_fail++; $display("FAIL rstmid_outputs: got valid=%b rdv=%b conf=%b under=%b data=%h expected all 0", bus_req_valid, avs_readdatavalid, err_rw_conflict, err_resp_underflow, avs_readdata); end
    avs_read = 1'b1;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rstmid_cnt_clear: got wait=%b expected 0", avs_waitrequest); end
    avs_read = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_readdata = 16'h7777;
    tick();
    bus_resp_valid = 1'b0;
    #1;
    n_checks++; if (err_resp_underflow !== 1'b1) begin n_fail++; $display("FAIL rstmid_late_resp: got %b expected 1", err_resp_underflow); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 79) != 0);
      init_done      = ($urandom_range(0, 9) != 0);
      avs_read       = ($urandom_range(0, 2) == 0);
      avs_write      = ($urandom_range(0, 3) == 0);
      avs_address    = AW'($urandom);
      avs_writedata  = DW'($urandom);
      avs_byteenable = BE'($urandom);
      bus_req_ready  = ($urandom_range(0, 1) == 0);
      bus_resp_valid = ($urandom_range(0, 3) == 0);
      bus_resp_readdata = DW'($urandom);
      #1;
      n_checks++; if (avs_waitrequest !== exp_wait()) begin n_fail++; $display("FAIL rnd_wait cyc %0d: got %b expected %b", c, avs_waitrequest, exp_wait()); end
      n_checks++; if (bus_req_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", c, bus_req_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++;
        if ({bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable} !== {q[0].w, q[0].a, q[0].d, q[0].be})
          begin n_fail++; $display("FAIL rnd_payload cyc %0d: got w=%b a=%h d=%h be=%b expected w=%b a=%h d=%h be=%b", c, bus_req_write, bus_req_address, bus_req_writedata, bus_req_byteenable, q[0].w, q[0].a, q[0].d, q[0].be); end
      end
      n_checks++; if (avs_readdatavalid !== m_rdv || avs_readdata !== m_rdata) begin n_fail++; $display("FAIL rnd_resp cyc %0d: got rdv=%b data=%h expected rdv=%b data=%h", c, avs_readdatavalid, avs_readdata, m_rdv, m_rdata); end
      n_checks++; if (err_rw_conflict !== m_conf || err_resp_underflow !== m_under) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %b%b expected %b%b", c, err_rw_conflict, err_resp_underflow, m_conf, m_under); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; init_done = 1'b0; idle_inputs();
    @(negedge clk);
    test_reset();
    test_init_gate();
    test_fifo_full();
    test_read_limit();
    test_same_cycle();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
